// File: rtl/regfile_mp.sv
// Two-read/two-write register file with hardwired zero entry, write bypass and bulk clear.
// Latency: reads combinational; writes visible the cycle after the edge; clear takes 2**ADDR_W cycles.
// Backpressure: none; writes arriving while a clear is running are dropped and flagged on wr_drop.
//
// Ports:
//   clock, reset              - rising-edge clock, async active-high reset (zeroes storage, FSM to IDLE)
//   rd_addr_a/b, rd_data_a/b  - two combinational read ports (optional same-cycle write bypass)
//   wr0_*, wr1_*              - two write ports; wr1 wins on an address collision
//   clear_req/busy/done       - bulk-clear handshake: request in IDLE, busy while clearing, one-cycle done
//   wr_drop                   - registered; a write was discarded by the clear in the previous cycle
//   flag_zero, flag_neg       - zero/sign of the condition register, from storage only
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int FLAG_REG = 12,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr_drop,
    output logic              flag_zero,
    output logic              flag_neg
);
    localparam int DEPTH = 2**ADDR_W;
    // Counter is one bit wider than the address so the final entry is an explicit value, not a wrap.
    localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_REG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_drop;
    logic              w_busy;
    logic              w_wr0_ok;
    logic              w_wr1_ok;

    assign w_busy = (r_state == S_CLEAR);

    // Writes are accepted only outside a clear and never to the hardwired zero entry.
    assign w_wr0_ok = wr0_en && !w_busy && !(ZERO_REG && (wr0_addr == '0));
    assign w_wr1_ok = wr1_en && !w_busy && !(ZERO_REG && (wr1_addr == '0));

    // ---------------- clear FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clear_busy = w_busy;
    assign clear_done = (r_state == S_DONE);

    // ---------------- storage ----------------
    // wr1 is assigned after wr0 so it takes precedence when both hit the same entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_wr_drop <= 1'b0;
        else       r_wr_drop <= w_busy && (wr0_en || wr1_en);
    end

    assign wr_drop = r_wr_drop;

    // ---------------- read ports ----------------
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        logic              is_zero;
        is_zero = ZERO_REG && (a == '0);
        v       = r_mem[a];
        // Bypass is suppressed during a clear so reads reflect what storage will actually hold.
        if (BYPASS && !w_busy && !is_zero) begin
            if (wr1_en && (wr1_addr == a))      v = wr1_data;
            else if (wr0_en && (wr0_addr == a)) v = wr0_data;
        end
        if (is_zero) v = '0;
        return v;
    endfunction

    assign rd_data_a = f_read(rd_addr_a);
    assign rd_data_b = f_read(rd_addr_b);

    // Flags come from committed storage only, never from bypassed data.
    assign flag_zero = (r_mem[FLAG_IDX] == '0);
    assign flag_neg  = r_mem[FLAG_IDX][DATA_W-1];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic        clock;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr0_en, wr1_en;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        clear_req;
    logic        clear_busy, clear_done, wr_drop, flag_zero, flag_neg;
    logic [31:0] nb_rd_data_a, nb_rd_data_b;
    logic        nb_clear_busy, nb_clear_done, nb_wr_drop, nb_flag_zero, nb_flag_neg;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .FLAG_REG(12), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .wr_drop(wr_drop), .flag_zero(flag_zero), .flag_neg(flag_neg)
    );

    // Second instance without bypass, driven by the same stimulus.
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .FLAG_REG(12), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clear_req(clear_req), .clear_busy(nb_clear_busy), .clear_done(nb_clear_done),
        .wr_drop(nb_wr_drop), .flag_zero(nb_flag_zero), .flag_neg(nb_flag_neg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m [32];   // reference model of storage

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1 later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        clear_req = 1'b0;
    endtask

    task automatic check_all_entries(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            expect_val({tag, "_a"}, m[i]);
            expect_val({tag, "_b"}, m[31 - i]);
            #1;
            chk(rd_data_a);
            chk(rd_data_b);
        end
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        int done_at;

        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) m[i] = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // ---- reset state ----
        check_all_entries("reset_read");
        expect_val("reset_flag_zero", 32'd1);  chk(32'(flag_zero));
        expect_val("reset_flag_neg", 32'd0);   chk(32'(flag_neg));
        expect_val("reset_busy", 32'd0);       chk(32'(clear_busy));
        expect_val("reset_done", 32'd0);       chk(32'(clear_done));
        expect_val("reset_wr_drop", 32'd0);    chk(32'(wr_drop));

        // ---- single write and bypass ----
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        rd_addr_a = 5'd5;
        expect_val("bypass_same_cycle", 32'hDEADBEEF);
        expect_val("nobypass_same_cycle", 32'h0);
        #1;
        chk(rd_data_a);
        chk(nb_rd_data_a);
        tick();
        m[5] = 32'hDEADBEEF;
        idle_inputs();
        expect_val("write_visible", m[5]);
        expect_val("nb_write_visible", m[5]);
        #1;
        chk(rd_data_a);
        chk(nb_rd_data_a);

        // ---- write collision: wr1 wins ----
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr_a = 5'd7;
        expect_val("collide_bypass", 32'h22);
        #1;
        chk(rd_data_a);
        tick();
        m[7] = 32'h22;
        idle_inputs();
        expect_val("collide_stored", m[7]);
        expect_val("collide_no_drop", 32'd0);
        #1;
        chk(rd_data_a);
        chk(32'(wr_drop));

        // ---- zero register ----
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hAB;
        rd_addr_a = 5'd0;
        expect_val("zero_reg_no_bypass", 32'h0);
        #1;
        chk(rd_data_a);
        tick();
        idle_inputs();
        expect_val("zero_reg_read", 32'h0);
        #1;
        chk(rd_data_a);

        // ---- flags ----
        tick();
        wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h80000000;
        expect_val("flag_not_bypassed", 32'd1);
        #1;
        chk(32'(flag_zero));
        tick();
        m[12] = 32'h80000000;
        idle_inputs();
        expect_val("flag_neg_set", 32'd1);
        expect_val("flag_zero_clr", 32'd0);
        #1;
        chk(32'(flag_neg));
        chk(32'(flag_zero));
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h0;
        tick();
        m[12] = 32'h0;
        idle_inputs();
        expect_val("flag_zero_set", 32'd1);
        expect_val("flag_neg_clr", 32'd0);
        #1;
        chk(32'(flag_zero));
        chk(32'(flag_neg));

        // ---- fill everything, then bulk clear ----
        for (int i = 0; i < 32; i++) begin
            tick();
            wr0_en = 1'b1; wr0_addr = 5'(i); wr0_data = 32'hFFFFFFFF;
            if (i != 0) m[i] = 32'hFFFFFFFF;
        end
        tick();
        idle_inputs();
        #1;
        check_all_entries("filled");
        tick();
        clear_req = 1'b1;
        tick();
        busy_cycles = 0;
        done_pulses = 0;
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            // clear_req pulses during CLEAR and DONE must be ignored
            clear_req = (c == 20) || (c == 32);
            wr0_en    = (c == 5);
            wr0_addr  = 5'd3;
            wr0_data  = 32'h1234;
            rd_addr_a = (c == 10) ? 5'd9 : 5'd3;
            rd_addr_b = 5'd10;
            #1;
            if (clear_busy) busy_cycles++;
            if (clear_done) begin
                done_pulses++;
                done_at = c;
            end
            if (c == 5) begin
                expect_val("no_bypass_in_clear", 32'h0);
                chk(rd_data_a);
            end
            if (c == 10) begin
                expect_val("mid_clear_below_cnt", 32'h0);
                expect_val("mid_clear_at_cnt", 32'hFFFFFFFF);
                chk(rd_data_a);
                chk(rd_data_b);
            end
            if (c == 6) begin
                expect_val("wr_drop_set", 32'd1);
                chk(32'(wr_drop));
            end
            if (c == 7) begin
                expect_val("wr_drop_clr", 32'd0);
                chk(32'(wr_drop));
            end
            tick();
        end
        idle_inputs();
        expect_val("clear_busy_cycles", 32'd32);
        expect_val("clear_done_pulses", 32'd1);
        expect_val("clear_done_cycle", 32'd32);
        chk(32'(busy_cycles));
        chk(32'(done_pulses));
        chk(32'(done_at));
        for (int i = 0; i < 32; i++) m[i] = '0;
        #1;
        check_all_entries("after_clear");

        // ---- reset in the middle of a clear ----
        for (int i = 20; i < 26; i++) begin
            tick();
            wr1_en = 1'b1; wr1_addr = 5'(i); wr1_data = 32'hA5A5_0000 | 32'(i);
        end
        tick();
        idle_inputs();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        rd_addr_a = 5'd20;
        expect_val("pre_abort_busy", 32'd1);
        expect_val("pre_abort_entry20", 32'hA5A50014);
        #1;
        chk(32'(clear_busy));
        chk(rd_data_a);
        reset = 1'b1;
        expect_val("abort_busy", 32'd0);
        expect_val("abort_done", 32'd0);
        expect_val("abort_entry20", 32'h0);
        #1;
        chk(32'(clear_busy));
        chk(32'(clear_done));
        chk(rd_data_a);
        tick();
        reset = 1'b0;
        done_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (clear_done || clear_busy) done_pulses++;
            tick();
        end
        expect_val("abort_no_activity", 32'd0);
        chk(32'(done_pulses));
        check_all_entries("after_abort");

        // ---- fresh clear after abort ----
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (clear_busy) busy_cycles++;
            if (clear_done) done_pulses++;
            tick();
        end
        expect_val("fresh_clear_busy_cycles", 32'd32);
        expect_val("fresh_clear_done_pulses", 32'd1);
        chk(32'(busy_cycles));
        chk(32'(done_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised two-read/two-write register file for the CPU datapath. Storage depth and data width are configurable. Supports a hardwired zero register and optional write-to-read bypass. Includes a sequential bulk-clear engine, so software and the controller can zero the file without asserting global reset. Exports zero/negative flags of a designated condition register to the controller.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
FLAG_REG, 12, index of the condition register driving the flags; must match controller constant
ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, 1 = reads return same-cycle write data on address match

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears storage and FSM
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable; higher priority
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
clear_req  in  1  start bulk clear (sampled in IDLE)
clear_busy  out  1  high while the clear is in progress
clear_done  out  1  one-cycle pulse after the last entry is cleared
wr_drop  out  1  registered; high the cycle after any enabled write was discarded by a clear
flag_zero  out  1  storage[FLAG_REG] == 0 (combinational)
flag_neg  out  1  storage[FLAG_REG][DATA_W-1] (combinational)

Behaviour:
- Reset: reset is asynchronous, active-high. All entries are set to 0 and the FSM goes to IDLE, counter 0. Outputs after reset: clear_busy=0, clear_done=0, wr_drop=0, flag_zero=1, flag_neg=0.
- Writes commit on the rising clock edge. The written value is visible in storage on the following cycle.
- Same address on both write ports in one cycle: wr1 wins and wr0 is discarded silently. wr_drop is not asserted.
- When ZERO_REG=1, writes to address 0 are discarded and reads of address 0 return 0.
- Reads are combinational from storage. A read of an unwritten entry returns 0 after reset.
- Bypass (BYPASS=1): if rd_addr matches an enabled write address in the same cycle, rd_data is that write's data.
  - If both write ports match, wr1 data is returned.
  - No bypass for address 0 when ZERO_REG=1.
  - No bypass while clear_busy=1.
  - BYPASS=0: reads return the pre-edge storage contents.
- Flags are taken from storage only and are never bypassed. They update the cycle after a write to FLAG_REG.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_req=1 moves to CLEAR with cnt=0.
  - CLEAR: clear_busy=1. Each edge writes 0 to storage[cnt], then cnt increments. The edge that clears entry 2**ADDR_W-1 moves to DONE. The clear therefore takes exactly 2**ADDR_W cycles.
  - DONE: clear_done=1 for one cycle, then unconditionally back to IDLE. clear_req during DONE is ignored; a new clear needs clear_req in IDLE.
- clear_req during CLEAR is ignored; there is no restart.
- Writes during CLEAR (either port, any address) are discarded. wr_drop goes high the next cycle.
- Reads during CLEAR return current storage: entries with index < cnt read 0, the rest keep their old values.
- Reset during CLEAR aborts immediately: storage is zeroed, the FSM goes to IDLE, clear_done is not pulsed.
- cnt is ADDR_W+1 bits wide, so the terminal count is detected without wrap ambiguity.

Test Plan:
- Reset, then read addresses 0..31 on both ports -> all return 0; flag_zero=1, flag_neg=0, clear_busy=0.
- wr0 writes 0xDEADBEEF to addr 5; next cycle rd_addr_a=5 -> 0xDEADBEEF. Same-cycle read of addr 5 with BYPASS=1 -> 0xDEADBEEF; with BYPASS=0 -> 0.
- Same cycle: wr0 writes 0x11 to addr 7 and wr1 writes 0x22 to addr 7 -> storage[7]=0x22, same-cycle bypass read returns 0x22, wr_drop=0. Write 0xAB to addr 0 with ZERO_REG=1 -> addr 0 reads 0.
- Write 0x80000000 to addr 12 -> next cycle flag_neg=1, flag_zero=0. Write 0 to addr 12 -> next cycle flag_zero=1, flag_neg=0.
- Fill all entries with 0xFFFFFFFF, pulse clear_req:
  - clear_busy stays high for 32 cycles.
  - Mid-clear at cnt=10: addr 9 reads 0 and addr 10 reads 0xFFFFFFFF.
  - A wr0 write to addr 3 during the clear is discarded and wr_drop=1 the next cycle.
  - clear_done pulses once; all entries then read 0.
- Assert reset at cycle 15 of a clear -> clear_busy=0 immediately, no clear_done pulse, all entries read 0. A fresh clear_req afterwards completes in 32 cycles.
